// File: rtl/clk_div_ctrl_pkg.sv
// ============================================================================
// Module   : clk_div_ctrl_pkg
// Brief    : State encodings and ratio normalisation shared by clk_div_ctrl.
//            The STEP state exists only when CLK_DIV_CTRL_STEP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_ctrl_pkg;

    localparam int c_state_w = 2;

    localparam logic [c_state_w-1:0] c_st_halt = 2'd0;
    localparam logic [c_state_w-1:0] c_st_run  = 2'd1;
`ifdef CLK_DIV_CTRL_STEP_EN
    localparam logic [c_state_w-1:0] c_st_step = 2'd2;
`endif

    // Ratios 0 and 1 both mean "enable every cycle".
    function automatic logic [31:0] norm_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd1 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ctrl_cnt.sv
// ============================================================================
// Module   : clk_div_ctrl_cnt
// Brief    : Modulo-N period counter with synchronous clear and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             w_tc;

    assign w_tc  = (r_cnt == (i_n - c_one));
    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Run-time programmable clock-enable generator with run/halt
//            sequencing and boundary-aligned ratio changes.
//            Optional single-step support: define CLK_DIV_CTRL_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic             clk_ref,
    input  logic             arst,
    input  logic             run,
    input  logic             div_req,
    input  logic [WIDTH-1:0] div_val,
`ifdef CLK_DIV_CTRL_STEP_EN
    input  logic             step,
`endif
    output logic             div_ack,
    output logic             clk_en,
    output logic             clk_out,
    output logic             halted
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;

    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_pend;
    logic             r_div_ack;

    logic [WIDTH-1:0] w_n;
    logic [WIDTH-1:0] w_cnt;
    logic             w_tc;
    logic             w_active;
    logic             w_apply;
    logic             w_latch;
    logic             w_cnt_clr;

    assign w_n = WIDTH'(norm_div(32'(r_div_q)));

    clk_div_ctrl_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk_ref),
        .rst   (arst),
        .i_clr (w_cnt_clr),
        .i_n   (w_n),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk_ref or posedge arst) begin
        if (arst) begin
            r_state <= c_st_halt;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_active    = (r_state != c_st_halt);
        // Halted: a pending ratio lands on the next edge; otherwise only at a boundary.
        w_apply     = r_pend && (!w_active || w_tc);
        w_latch     = div_req && !r_pend && !r_div_ack;
        w_cnt_clr   = !w_active || w_apply;

        case (r_state)
            c_st_halt: begin
                if (run) begin
                    w_state_nxt = c_st_run;
`ifdef CLK_DIV_CTRL_STEP_EN
                end else if (step) begin
                    w_state_nxt = c_st_step;
`endif
                end
            end
            c_st_run: begin
                if (w_tc && !run) begin
                    w_state_nxt = c_st_halt;
                end
            end
`ifdef CLK_DIV_CTRL_STEP_EN
            c_st_step: begin
                if (w_tc) begin
                    w_state_nxt = c_st_halt;
                end
            end
`endif
            default: begin
                w_state_nxt = c_st_halt;
            end
        endcase
    end

    always_ff @(posedge clk_ref or posedge arst) begin
        if (arst) begin
            r_div_q    <= WIDTH'(RESET_DIV);
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_div_ack  <= 1'b0;
        end else begin
            r_div_ack <= w_apply;
            if (w_apply) begin
                r_div_q <= r_pend_val;
                r_pend  <= 1'b0;
            end else if (w_latch) begin
                r_pend_val <= div_val;
                r_pend     <= 1'b1;
            end
        end
    end

    // All outputs decode registered state only.
    assign div_ack = r_div_ack;
    assign clk_en  = w_active && w_tc;
    assign clk_out = w_active && (w_cnt < (w_n >> 1));
    assign halted  = !w_active;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Scoreboard bench for clk_div_ctrl against a period-level model.
//            Single-step scenarios run when CLK_DIV_CTRL_STEP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

`ifdef CLK_DIV_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       clk_ref = 1'b0;
    logic       arst    = 1'b1;
    logic       run     = 1'b0;
    logic       div_req = 1'b0;
    logic       step    = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_ack;
    logic       clk_en;
    logic       clk_out;
    logic       halted;

    always #5 clk_ref = ~clk_ref;

    clk_div_ctrl #(
        .WIDTH     (8),
        .RESET_DIV (4)
    ) dut (
        .clk_ref (clk_ref),
        .arst    (arst),
        .run     (run),
        .div_req (div_req),
        .div_val (div_val),
`ifdef CLK_DIV_CTRL_STEP_EN
        .step    (step),
`endif
        .div_ack (div_ack),
        .clk_en  (clk_en),
        .clk_out (clk_out),
        .halted  (halted)
    );

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    // Model: mode 0 = halted, 1 = running, 2 = single period; pos = cycle within period.
    int m_mode, m_pos, m_div, m_pend, m_pval, m_ack;
    bit req_active = 1'b0;
    int req_val    = 0;
    bit run_lvl    = 1'b0;

    function int eff(input int d);
        return (d < 2) ? 1 : d;
    endfunction

    function logic [3:0] model_out();
        int n;
        logic en, co, hl;
        n  = eff(m_div);
        en = (m_mode != 0) && (m_pos == n - 1);
        co = (m_mode != 0) && (m_pos < n / 2);
        hl = (m_mode == 0);
        return {en, co, hl, (m_ack != 0)};
    endfunction

    task model_reset();
        m_mode = 0; m_pos = 0; m_div = 4; m_pend = 0; m_pval = 0; m_ack = 0;
    endtask

    task model_step(input bit a_run, input bit a_req, input bit a_step, input int a_val);
        int n, nmode, npos;
        bit bnd, apply, latch;
        n     = eff(m_div);
        bnd   = (m_mode != 0) && (m_pos == n - 1);
        apply = (m_pend != 0) && (m_mode == 0 || bnd);
        latch = a_req && (m_pend == 0) && (m_ack == 0);
        nmode = m_mode;
        if (m_mode == 0) begin
            npos = 0;
            if (a_run) nmode = 1;
            else if (STEP_EN && a_step) nmode = 2;
        end else begin
            npos = bnd ? 0 : m_pos + 1;
            if (bnd && (m_mode == 2 || !a_run)) nmode = 0;
        end
        if (apply) begin
            m_div  = m_pval;
            m_pend = 0;
            npos   = 0;
        end
        if (latch) begin
            m_pend = 1;
            m_pval = a_val;
        end
        m_ack  = apply ? 1 : 0;
        m_mode = nmode;
        m_pos  = npos;
    endtask

    task check(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: en/out/halted/ack actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and queue the post-edge outputs.
    task tick(input bit a_run, input bit a_step, input bit a_rst);
        @(negedge clk_ref);
        if (m_ack != 0) req_active = 1'b0;
        run     = a_run;
        step    = a_step;
        arst    = a_rst;
        div_req = req_active;
        div_val = req_val[7:0];
        if (a_rst) model_reset();
        else model_step(a_run, req_active, a_step, req_val);
        exp_q.push_back(model_out());
    endtask

    task reset_now();
        @(negedge clk_ref);
        arst       = 1'b1;
        run        = 1'b0;
        run_lvl    = 1'b0;
        req_active = 1'b0;
        div_req    = 1'b0;
        model_reset();
        #1;
        check("async_reset", {clk_en, clk_out, halted, div_ack}, 4'b0010);
        exp_q.push_back(model_out());
    endtask

    task wait_pos(input int p, input bit r);
        for (int i = 0; i < 64; i++) begin
            if (m_mode != 0 && m_pos == p) break;
            tick(r, 1'b0, 1'b0);
        end
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clk_ref);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {clk_en, clk_out, halted, div_ack}, e);
            end
        end
    end

    initial begin : stimulus
        model_reset();
        #1;
        check("reset_state", {clk_en, clk_out, halted, div_ack}, 4'b0010);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);

        // Default ratio free-running
        repeat (14) tick(1'b1, 1'b0, 1'b0);

        // Ratio change to 3 requested at cnt=1
        wait_pos(1, 1'b1);
        req_val = 3; req_active = 1'b1;
        repeat (16) tick(1'b1, 1'b0, 1'b0);

        // Degenerate ratios programmed while halted
        repeat (6) tick(1'b0, 1'b0, 1'b0);
        req_val = 0; req_active = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        req_val = 1; req_active = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);

        // Graceful halt with N=4, run dropped at cnt=1
        req_val = 4; req_active = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0, 1'b0);
        wait_pos(1, 1'b1);
        repeat (8) tick(1'b0, 1'b0, 1'b0);

        // Reset at cnt=2 with a request pending
        req_val = 7; req_active = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        wait_pos(1, 1'b1);
        req_val = 6; req_active = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        reset_now();
        tick(1'b0, 1'b0, 1'b1);
        repeat (12) tick(1'b1, 1'b0, 1'b0);

        if (STEP_EN) begin
            repeat (6) tick(1'b0, 1'b0, 1'b0);
            req_val = 5; req_active = 1'b1;
            repeat (3) tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
            repeat (8) tick(1'b0, 1'b0, 1'b0);
            repeat (3) tick(1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b1, 1'b0);
            repeat (10) tick(1'b1, 1'b0, 1'b0);
            repeat (8) tick(1'b0, 1'b0, 1'b0);
        end

        // Randomized operation
        run_lvl = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            bit stp;
            if ($urandom % 40 == 0) run_lvl = !run_lvl;
            if (!req_active && m_pend == 0 && m_ack == 0 && $urandom % 25 == 0)
                req_active = 1'b1;
            req_val = int'($urandom % 8);
            stp = ($urandom % 16 == 0);
            if ($urandom % 700 == 0) begin
                reset_now();
                tick(1'b0, 1'b0, 1'b1);
            end else begin
                tick(run_lvl, stp, 1'b0);
            end
        end

        repeat (3) tick(1'b0, 1'b0, 1'b0);
        @(posedge clk_ref);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
